// File: rtl/hazard_ctrl_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl_multi_pkg
// Brief  : Shared stage indices, controller state encoding and width helper
//          for the multi-source pipeline hazard controller.
// Rev    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_multi_pkg;

   // Bit positions inside the hold/flush vectors
   localparam int STG_PC    = 0;
   localparam int STG_IFID  = 1;
   localparam int STG_IDEX  = 2;
   localparam int STG_EXMEM = 3;
   localparam int MIN_STAGES = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LU_STALL  = 2'd1,
      ST_DIV_STALL = 2'd2
   } hz_state_e;

   // Counter width able to hold values 0..n-1, never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl_multi_if
// Brief  : Pipeline <-> hazard controller signal bundle. The pipeline side
//          (master) reports bus/decode/execute status and receives the
//          per-stage hold and flush vectors.
// Rev    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_multi_if #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_STAGES = 4
) ();
   typedef logic [NUM_STAGES-1:0] stage_bus_t;

   logic                  busy;
   logic                  jump;
   logic [REG_ADDR_W-1:0] ID_rs1;
   logic [REG_ADDR_W-1:0] ID_rs2;
   logic                  ID_rs1_en;
   logic                  ID_rs2_en;
   logic [REG_ADDR_W-1:0] EX_rd;
   logic                  EX_rmem;
   logic                  EX_div;
   stage_bus_t            hold;
   stage_bus_t            flush;

   modport master (
      output busy, jump, ID_rs1, ID_rs2, ID_rs1_en, ID_rs2_en, EX_rd, EX_rmem, EX_div,
      input  hold, flush
   );

   modport slave (
      input  busy, jump, ID_rs1, ID_rs2, ID_rs1_en, ID_rs2_en, EX_rd, EX_rmem, EX_div,
      output hold, flush
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_multi_stall_cnt.sv
`default_nettype none
// ============================================================================
// Module : hazard_stall_cnt
// Brief  : Load / decrement down-counter with freeze and zero flag. Load wins
//          over freeze so a stall can be armed while the bus is busy.
// Rev    : 1.0 - initial release
// ============================================================================
module hazard_stall_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   input  logic             i_freeze,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_zero
);
   logic [WIDTH-1:0] r_cnt;

   // Count register: load, else decrement (saturating at zero) unless frozen
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && !i_freeze && (r_cnt != '0)) begin
         r_cnt <= r_cnt - WIDTH'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl_multi
// Brief  : Per-stage hold/flush generator combining bus-busy freeze, jump
//          flush, load-use bubble insertion and multi-cycle divide stall.
//          Pending jumps and bubbles survive busy periods.
// Rev    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_multi
   import hazard_ctrl_multi_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_STAGES = 4,
   parameter int LU_BUBBLES = 1,
   parameter int DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rstn,
   hazard_ctrl_multi_if.slave bus
);
   localparam int LU_W  = cnt_w(LU_BUBBLES + 1);
   localparam int DIV_W = cnt_w(DIV_CYCLES);

   hz_state_e               r_state, w_state_nxt;
   logic                    r_jump_pend, w_jump_pend_nxt;
   logic [NUM_STAGES-1:0]   w_hold, w_flush;
   logic                    w_hazard, w_jump_req;
   logic                    w_lu_load, w_lu_dec, w_lu_zero;
   logic [LU_W-1:0]         w_lu_val, w_lu_cnt;
   logic                    w_div_load, w_div_dec, w_div_zero;
   logic [DIV_W-1:0]        w_div_cnt;
   logic                    w_unused;

   // Only the zero flag of the divide counter drives decisions
   assign w_unused = ^w_div_cnt;

   // x0 is hard-wired zero, so a load into it can never create a hazard
   assign w_hazard = bus.EX_rmem && (bus.EX_rd != '0) &&
                     ((bus.ID_rs1_en && (bus.ID_rs1 == bus.EX_rd)) ||
                      (bus.ID_rs2_en && (bus.ID_rs2 == bus.EX_rd)));
   assign w_jump_req = bus.jump || r_jump_pend;

   // Next-state, counter control and hold/flush generation
   always_comb begin
      w_state_nxt     = r_state;
      w_jump_pend_nxt = r_jump_pend;
      w_hold          = '0;
      w_flush         = '0;
      w_lu_load       = 1'b0;
      w_lu_val        = '0;
      w_lu_dec        = 1'b0;
      w_div_load      = 1'b0;
      w_div_dec       = 1'b0;
      if (bus.busy) begin
         // Whole pipe frozen; only arm stalls from IDLE and remember jumps
         w_hold          = '1;
         w_jump_pend_nxt = w_jump_req;
         if (r_state == ST_IDLE) begin
            if (bus.EX_div) begin
               w_state_nxt = ST_DIV_STALL;
               w_div_load  = 1'b1;
            end else if (w_hazard && !w_jump_req) begin
               // No bubble issued yet, so all of them are still owed
               w_state_nxt = ST_LU_STALL;
               w_lu_load   = 1'b1;
               w_lu_val    = LU_W'(LU_BUBBLES);
            end
         end
      end else begin
         case (r_state)
            ST_DIV_STALL: begin
               // A jump seen while the divide owns EX waits for the release
               w_jump_pend_nxt = w_jump_req;
               if (w_div_zero) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_hold[STG_IDEX:STG_PC] = 3'b111;
                  w_flush[STG_EXMEM]      = 1'b1;
                  w_div_dec               = 1'b1;
               end
            end
            default: begin
               if (w_jump_req) begin
                  // Squashes the ID instruction, so any owed bubbles are void
                  w_flush[STG_IFID] = 1'b1;
                  w_flush[STG_IDEX] = 1'b1;
                  w_jump_pend_nxt   = 1'b0;
                  w_state_nxt       = ST_IDLE;
               end else if (r_state == ST_LU_STALL) begin
                  w_hold[STG_IFID:STG_PC] = 2'b11;
                  w_flush[STG_IDEX]       = 1'b1;
                  w_lu_dec                = 1'b1;
                  if (w_lu_zero || (w_lu_cnt == LU_W'(1))) begin
                     w_state_nxt = ST_IDLE;
                  end
               end else if (bus.EX_div) begin
                  w_state_nxt = ST_DIV_STALL;
                  w_div_load  = 1'b1;
               end else if (w_hazard) begin
                  w_hold[STG_IFID:STG_PC] = 2'b11;
                  w_flush[STG_IDEX]       = 1'b1;
                  if (LU_BUBBLES > 1) begin
                     w_state_nxt = ST_LU_STALL;
                     w_lu_load   = 1'b1;
                     w_lu_val    = LU_W'(LU_BUBBLES - 1);
                  end
               end
            end
         endcase
      end
   end

   // State and pending-jump registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_jump_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_jump_pend <= w_jump_pend_nxt;
      end
   end

   hazard_stall_cnt #(.WIDTH(LU_W)) u_lu_cnt (
      .clk        (clk),
      .rstn       (rstn),
      .i_load     (w_lu_load),
      .i_load_val (w_lu_val),
      .i_dec      (w_lu_dec),
      .i_freeze   (bus.busy),
      .o_cnt      (w_lu_cnt),
      .o_zero     (w_lu_zero)
   );

   hazard_stall_cnt #(.WIDTH(DIV_W)) u_div_cnt (
      .clk        (clk),
      .rstn       (rstn),
      .i_load     (w_div_load),
      .i_load_val (DIV_W'(DIV_CYCLES - 1)),
      .i_dec      (w_div_dec),
      .i_freeze   (bus.busy),
      .o_cnt      (w_div_cnt),
      .o_zero     (w_div_zero)
   );

   // Outputs drop together with an asserted reset, independent of inputs
   assign bus.hold  = rstn ? w_hold  : '0;
   assign bus.flush = rstn ? w_flush : '0;

   a_jump_not_div: assert property (@(posedge clk) disable iff (!rstn) !(bus.jump && bus.EX_div));
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_ctrl_multi
// Brief  : Self-checking bench; two controllers (1 bubble / 4 stages and
//          3 bubbles / 5 stages, both 4-cycle divide) against a cycle model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_multi;
   localparam int RAW = 5;
   localparam int DC  = 4;

   logic clk = 1'b0;
   logic rstn;
   logic busy, jump, ID_rs1_en, ID_rs2_en, EX_rmem, EX_div;
   logic [RAW-1:0] ID_rs1, ID_rs2, EX_rd;

   always #5 clk = ~clk;

   hazard_ctrl_multi_if #(.REG_ADDR_W(RAW), .NUM_STAGES(4)) if_a ();
   hazard_ctrl_multi_if #(.REG_ADDR_W(RAW), .NUM_STAGES(5)) if_b ();

   assign if_a.busy = busy;       assign if_b.busy = busy;
   assign if_a.jump = jump;       assign if_b.jump = jump;
   assign if_a.ID_rs1 = ID_rs1;   assign if_b.ID_rs1 = ID_rs1;
   assign if_a.ID_rs2 = ID_rs2;   assign if_b.ID_rs2 = ID_rs2;
   assign if_a.ID_rs1_en = ID_rs1_en; assign if_b.ID_rs1_en = ID_rs1_en;
   assign if_a.ID_rs2_en = ID_rs2_en; assign if_b.ID_rs2_en = ID_rs2_en;
   assign if_a.EX_rd = EX_rd;     assign if_b.EX_rd = EX_rd;
   assign if_a.EX_rmem = EX_rmem; assign if_b.EX_rmem = EX_rmem;
   assign if_a.EX_div = EX_div;   assign if_b.EX_div = EX_div;

   hazard_ctrl_multi #(.REG_ADDR_W(RAW), .NUM_STAGES(4), .LU_BUBBLES(1), .DIV_CYCLES(DC)) u_dut_a (
      .clk(clk), .rstn(rstn), .bus(if_a.slave));
   hazard_ctrl_multi #(.REG_ADDR_W(RAW), .NUM_STAGES(5), .LU_BUBBLES(3), .DIV_CYCLES(DC)) u_dut_b (
      .clk(clk), .rstn(rstn), .bus(if_b.slave));

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: owed bubbles, remaining divide hold cycles, pending jump
   int lb[2] = '{1, 3};
   int ns[2] = '{4, 5};
   int m_lu[2], m_div[2], x_lu[2], x_div[2];
   bit m_dact[2], m_pend[2], x_dact[2], x_pend[2];
   logic [31:0] e_hold[2], e_flush[2];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] act_hold(input int k);
      return (k == 0) ? 32'(if_a.hold) : 32'(if_b.hold);
   endfunction

   function automatic logic [31:0] act_flush(input int k);
      return (k == 0) ? 32'(if_a.flush) : 32'(if_b.flush);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_lu[k] = 0; m_div[k] = 0; m_dact[k] = 1'b0; m_pend[k] = 1'b0;
      end
   endtask

   task automatic model_eval(input int k);
      bit haz, jreq, idle;
      haz  = EX_rmem && (EX_rd != 0) &&
             ((ID_rs1_en && ID_rs1 == EX_rd) || (ID_rs2_en && ID_rs2 == EX_rd));
      jreq = jump || m_pend[k];
      idle = (m_lu[k] == 0) && !m_dact[k];
      x_lu[k] = m_lu[k]; x_div[k] = m_div[k]; x_dact[k] = m_dact[k]; x_pend[k] = m_pend[k];
      e_hold[k] = 32'h0; e_flush[k] = 32'h0;
      if (!rstn) begin
         x_lu[k] = 0; x_div[k] = 0; x_dact[k] = 1'b0; x_pend[k] = 1'b0;
      end else if (busy) begin
         e_hold[k] = (32'd1 << ns[k]) - 32'd1;
         x_pend[k] = jreq;
         if (idle) begin
            if (EX_div) begin x_dact[k] = 1'b1; x_div[k] = DC - 1; end
            else if (haz && !jreq) x_lu[k] = lb[k];
         end
      end else if (m_dact[k]) begin
         x_pend[k] = jreq;
         if (m_div[k] == 0) x_dact[k] = 1'b0;
         else begin e_hold[k] = 32'h7; e_flush[k] = 32'h8; x_div[k] = m_div[k] - 1; end
      end else if (jreq) begin
         e_flush[k] = 32'h6; x_pend[k] = 1'b0; x_lu[k] = 0;
      end else if (m_lu[k] > 0) begin
         e_hold[k] = 32'h3; e_flush[k] = 32'h4; x_lu[k] = m_lu[k] - 1;
      end else if (EX_div) begin
         x_dact[k] = 1'b1; x_div[k] = DC - 1;
      end else if (haz) begin
         e_hold[k] = 32'h3; e_flush[k] = 32'h4; x_lu[k] = lb[k] - 1;
      end
   endtask

   task automatic settle();
      #3;
      for (int k = 0; k < 2; k++) begin
         model_eval(k);
         chk((k == 0) ? "model_hold_a" : "model_hold_b", act_hold(k), e_hold[k]);
         chk((k == 0) ? "model_flush_a" : "model_flush_b", act_flush(k), e_flush[k]);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         m_lu[k] = x_lu[k]; m_div[k] = x_div[k]; m_dact[k] = x_dact[k]; m_pend[k] = x_pend[k];
      end
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic clear_inputs();
      busy = 1'b0; jump = 1'b0; EX_rmem = 1'b0; EX_div = 1'b0;
      ID_rs1_en = 1'b0; ID_rs2_en = 1'b0; ID_rs1 = '0; ID_rs2 = '0; EX_rd = '0;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      bit done;
      logic [31:0] h, f;

      // Reset
      rstn = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      settle();
      chk("rst_hold", act_hold(0), 32'h0);
      chk("rst_flush", act_flush(0), 32'h0);
      advance();
      rstn = 1'b1;
      settle();
      chk("idle_hold_b", act_hold(1), 32'h0);
      advance();

      // Load-use through rs2
      EX_rmem = 1'b1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_rs2_en = 1'b1;
      settle();
      chk("lu_hold", act_hold(0), 32'h3);
      chk("lu_flush", act_flush(0), 32'h4);
      chk("lu_flush_b", act_flush(1), 32'h4);
      advance();
      clear_inputs();
      settle();
      chk("lu_single", act_hold(0), 32'h0);
      advance();
      repeat (3) step();

      // Load into x0 never hazards
      EX_rmem = 1'b1; EX_rd = '0; ID_rs2 = '0; ID_rs2_en = 1'b1; ID_rs1_en = 1'b1;
      settle();
      chk("x0_hold", act_hold(0), 32'h0);
      chk("x0_flush", act_flush(0), 32'h0);
      advance();
      clear_inputs();

      // Jump together with a load-use hazard
      jump = 1'b1; EX_rmem = 1'b1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_rs2_en = 1'b1;
      settle();
      chk("jmp_flush", act_flush(0), 32'h6);
      chk("jmp_hold", act_hold(0), 32'h0);
      chk("jmp_flush_b", act_flush(1), 32'h6);
      advance();
      clear_inputs();
      settle();
      chk("jmp_no_bubble_a", act_hold(0), 32'h0);
      chk("jmp_no_bubble_b", act_hold(1), 32'h0);
      advance();

      // Jump latched during busy
      for (int c = 0; c < 3; c++) begin
         busy = 1'b1;
         jump = (c == 1);
         settle();
         chk("busy_hold", act_hold(0), 32'hF);
         chk("busy_hold_b", act_hold(1), 32'h1F);
         chk("busy_flush", act_flush(0), 32'h0);
         advance();
      end
      clear_inputs();
      settle();
      chk("pend_flush", act_flush(0), 32'h6);
      advance();
      settle();
      chk("pend_once", act_flush(0), 32'h0);
      advance();

      // Divide
      EX_div = 1'b1;
      settle();
      chk("div_first", act_hold(0), 32'h0);
      advance();
      clear_inputs();
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("div_hold", act_hold(0), 32'h7);
         chk("div_flush", act_flush(0), 32'h8);
         chk("div_flush_b", act_flush(1), 32'h8);
         advance();
      end
      settle();
      chk("div_release", act_hold(0), 32'h0);
      advance();

      // Divide stretched by two busy cycles
      EX_div = 1'b1;
      step();
      EX_div = 1'b0;
      n = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         busy = (c == 1 || c == 2);
         settle();
         h = act_hold(0);
         if (h[2:0] == 3'b111) n++;
         else done = 1'b1;
         advance();
      end
      busy = 1'b0;
      chk("div_busy_len", n, 5);

      // Three bubbles with busy on the second one
      EX_rmem = 1'b1; EX_rd = 5'd7; ID_rs1 = 5'd7; ID_rs1_en = 1'b1;
      n = 0;
      for (int c = 0; c < 8; c++) begin
         if (c >= 1) clear_inputs();
         busy = (c == 1);
         settle();
         h = act_hold(1);
         f = act_flush(1);
         if (h == 32'h3 && f == 32'h4) n++;
         advance();
      end
      clear_inputs();
      chk("lu3_bubbles", n, 3);

      // Reset in the middle of a divide stall
      EX_div = 1'b1;
      step();
      clear_inputs();
      step();
      settle();
      rstn = 1'b0;
      #1;
      chk("rst_mid_hold", act_hold(0), 32'h0);
      chk("rst_mid_flush", act_flush(0), 32'h0);
      chk("rst_mid_hold_b", act_hold(1), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      step();
      step();

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         busy      = ($urandom_range(0, 4) == 0);
         EX_div    = ($urandom_range(0, 11) == 0);
         jump      = !EX_div && ($urandom_range(0, 7) == 0);
         EX_rmem   = !EX_div && ($urandom_range(0, 2) == 0);
         EX_rd     = RAW'($urandom_range(0, 3));
         ID_rs1    = RAW'($urandom_range(0, 3));
         ID_rs2    = RAW'($urandom_range(0, 3));
         ID_rs1_en = 1'($urandom_range(0, 1));
         ID_rs2_en = 1'($urandom_range(0, 1));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
